operate_sequencer: RTL and testbench
====================================

OPERATE_SEQUENCER -- requirements
Module: operate_sequencer

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width; only 16 is supported.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to execute ir; sampled only in IDLE.
REQ-006 ir  in  16  LC-3 instruction word.
REQ-007 Out0, Out1  in  16 each  register-file read data for SR0 and SR1 (combinational, same cycle).
REQ-008 SR0, SR1  out  3 each  register-file read selects.
REQ-009 DR  out  3  destination register select.
REQ-010 WE  out  1  register-file write enable, one-cycle pulse.
REQ-011 Bus  out  16  write-back data.
REQ-012 nzp  out  3  condition codes {N,Z,P}, registered.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 illegal  out  1  qualifies done; high when the opcode is unsupported.

Function
REQ-016 The FSM SHALL have states IDLE, READ, EXEC and WB.
- IDLE -> READ on start=1, latching ir.
- READ -> EXEC -> WB -> IDLE unconditionally.
REQ-017 start SHALL be ignored in all states other than IDLE, including WB; the latched ir SHALL NOT change while busy=1.
REQ-018 In READ and EXEC, SR0 SHALL be ir[8:6] and SR1 SHALL be ir[2:0]; in IDLE both SHALL be 0.
REQ-019 At the end of READ the block SHALL register Out0 and Out1 as operands A and B.
REQ-020 Operand select: if ir[5]=1, B SHALL be sign-extended ir[4:0]; otherwise B SHALL be the registered Out1.
REQ-021 ALU operations:
- ADD (opcode 0001): A+B modulo 2^16, carry and overflow discarded.
- AND (0101): A&B.
- NOT (1001): ~A, with ir[5:0] ignored.
REQ-022 The result SHALL be registered at the end of EXEC.
REQ-023 In WB for a legal opcode: WE=1, DR=ir[11:9], Bus=result and done=1, all in the same cycle.
REQ-024 At the end of WB for a legal opcode, nzp SHALL load exactly one-hot: 100 if result[15]=1, 010 if result=0, otherwise 001.
REQ-025 Any other opcode SHALL traverse the same states; in WB done=1, illegal=1 and WE=0, and nzp SHALL be unchanged.
REQ-026 Outside WB, WE, done and illegal SHALL be 0, and Bus and DR SHALL be 0.
REQ-027 Latency SHALL be 3 cycles from the start-accept edge to the WB cycle; back-to-back throughput SHALL be one instruction per 4 cycles.

Reset
REQ-028 Asserting reset SHALL immediately force:
- state=IDLE;
- WE=done=illegal=busy=0;
- SR0=SR1=DR=0 and Bus=0;
- nzp=010;
- operand and result registers to 0.
REQ-029 Reset in any state, including mid-WB, SHALL abort the instruction with no further WE pulse; the first start is accepted on the first rising edge after deassertion.

Structure
REQ-030 Package lc3_pkg SHALL hold:
- opcode constants (OP_ADD, OP_AND, OP_NOT);
- the state enum;
- the NZP_RESET constant (010).
REQ-031 One combinational sub-module, lc3_alu (inputs: opcode, A, B; output: result), SHALL be instantiated. The sign extension and the FSM SHALL reside in operate_sequencer.

Verification
REQ-032 ADD: ir=0x1001 (DR=0, SR0=0, SR1=1), Out0=0x0005, Out1=0x0003 -> in the 3rd cycle after accept WE=1, DR=0, Bus=0x0008, done=1; the next cycle nzp=001.
REQ-033 ADD immediate: ir=0x16FF (R3=R3+(-1)), Out0=0x0001 -> Bus=0x0000, DR=3, nzp=010.
REQ-034 AND: ir=0x5283, Out0=0xF0F0, Out1=0xFF00 -> SR0=2, SR1=3 in READ; Bus=0xF000, DR=1, nzp=100.
REQ-035 NOT: ir=0x997F, Out0=0x0000 -> Bus=0xFFFF, DR=4, nzp=100. Then start=1 held during busy -> exactly one done per 4 cycles.
REQ-036 Illegal opcode: ir=0xF025 with nzp=001 -> done=1, illegal=1, WE never 1, nzp stays 001.
REQ-037 Reset abort: reset low during EXEC -> busy=0, nzp=010, no WE pulse for that instruction; a new start after release completes normally.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 operate-instruction definitions: opcodes, sequencer states, reset condition codes.
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [2:0] NZP_RESET = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/lc3_alu.sv
// Combinational LC-3 operate ALU (ADD, AND, NOT); unsupported opcodes yield zero.
module lc3_alu
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = A + B;
      OP_AND:  result = A & B;
      OP_NOT:  result = ~A;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/operate_sequencer.sv
// Four-state LC-3 operate sequencer: IDLE -> READ -> EXEC -> WB, write-back 3 cycles after accept.
// start is only sampled in IDLE, so a held start gives one instruction per 4 cycles.
module operate_sequencer
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] ir,
  input  logic [WIDTH-1:0] Out0,
  input  logic [WIDTH-1:0] Out1,
  output logic [2:0]       SR0,
  output logic [2:0]       SR1,
  output logic [2:0]       DR,
  output logic             WE,
  output logic [WIDTH-1:0] Bus,
  output logic [2:0]       nzp,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       nzp_q, nzp_d;

  logic [3:0]       opcode;
  logic             legal;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] alu_res;

  assign opcode = ir_q[15:12];
  assign legal  = is_legal_op(opcode);
  // Immediate form replaces the second register operand with sext(ir[4:0]).
  assign b_sel  = ir_q[5] ? {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]} : b_q;

  lc3_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (opcode),
    .A      (a_q),
    .B      (b_sel),
    .result (alu_res)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    nzp_d   = nzp_q;
    SR0     = 3'd0;
    SR1     = 3'd0;
    DR      = 3'd0;
    WE      = 1'b0;
    Bus     = '0;
    done    = 1'b0;
    illegal = 1'b0;
    busy    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          ir_d    = ir;
          state_d = READ;
        end
      end
      READ: begin
        SR0     = ir_q[8:6];
        SR1     = ir_q[2:0];
        a_d     = Out0;
        b_d     = Out1;
        state_d = EXEC;
      end
      EXEC: begin
        SR0     = ir_q[8:6];
        SR1     = ir_q[2:0];
        res_d   = alu_res;
        state_d = WB;
      end
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
        if (legal) begin
          WE  = 1'b1;
          DR  = ir_q[11:9];
          Bus = res_q;
          if (res_q[WIDTH-1])     nzp_d = 3'b100;
          else if (res_q == '0)   nzp_d = 3'b010;
          else                    nzp_d = 3'b001;
        end else begin
          illegal = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      nzp_q   <= NZP_RESET;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      nzp_q   <= nzp_d;
    end
  end

  assign nzp = nzp_q;

endmodule

// File: tb/tb_operate_sequencer.sv
// Directed self-checking bench for operate_sequencer using hand-computed LC-3 vectors.
module tb_operate_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] ir;
  logic [15:0] Out0;
  logic [15:0] Out1;
  logic [2:0]  SR0;
  logic [2:0]  SR1;
  logic [2:0]  DR;
  logic        WE;
  logic [15:0] Bus;
  logic [2:0]  nzp;
  logic        busy;
  logic        done;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  operate_sequencer #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ir      (ir),
    .Out0    (Out0),
    .Out1    (Out1),
    .SR0     (SR0),
    .SR1     (SR1),
    .DR      (DR),
    .WE      (WE),
    .Bus     (Bus),
    .nzp     (nzp),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one instruction from accept to the cycle after WB, checking every stage.
  // Packed WB view: {WE, done, illegal, DR, Bus}.
  task automatic run_instr(input string name, input logic [15:0] i_ir,
                           input logic [15:0] o0, input logic [15:0] o1,
                           input logic [2:0] exp_sr0, input logic [2:0] exp_sr1,
                           input logic [22:0] exp_wb, input logic [2:0] exp_nzp);
    logic [22:0] got_wb;
    ir = i_ir; Out0 = o0; Out1 = o1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ir = 16'h0000;
    checks++;
    if ({busy, SR0, SR1} !== {1'b1, exp_sr0, exp_sr1}) begin
      errors++;
      $display("FAIL %s_read busy/SR0/SR1 got %b/%0d/%0d want 1/%0d/%0d",
               name, busy, SR0, SR1, exp_sr0, exp_sr1);
    end
    @(posedge clk); #1;
    Out0 = 16'hDEAD; Out1 = 16'hBEEF;
    checks++;
    if ({busy, WE, done, illegal} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_exec busy/WE/done/illegal got %b%b%b%b want 1000",
               name, busy, WE, done, illegal);
    end
    @(posedge clk); #1;
    got_wb = {WE, done, illegal, DR, Bus};
    checks++;
    if (got_wb !== exp_wb) begin
      errors++;
      $display("FAIL %s_wb {WE,done,illegal,DR,Bus} got %h want %h", name, got_wb, exp_wb);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, WE, nzp} !== {3'b000, exp_nzp}) begin
      errors++;
      $display("FAIL %s_after busy/done/WE/nzp got %b%b%b/%b want 000/%b",
               name, busy, done, WE, nzp, exp_nzp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; ir = '0; Out0 = '0; Out1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, WE, done, illegal, SR0, SR1, DR, Bus, nzp} !== {4'b0, 9'd0, 16'h0, 3'b010}) begin
      errors++;
      $display("FAIL reset_state busy=%b WE=%b done=%b ill=%b SR0=%0d SR1=%0d DR=%0d Bus=%h nzp=%b want all 0, nzp=010",
               busy, WE, done, illegal, SR0, SR1, DR, Bus, nzp);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_add();
    run_instr("add", 16'h1001, 16'h0005, 16'h0003, 3'd0, 3'd1,
              {3'b110, 3'd0, 16'h0008}, 3'b001);
  endtask

  task automatic test_illegal();
    int we_seen = 0;
    int done_seen = 0;
    int ill_seen = 0;
    ir = 16'hF025; Out0 = 16'h1234; Out1 = 16'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (WE) we_seen++;
      if (done) done_seen++;
      if (done && illegal) ill_seen++;
      if (c == 2) begin
        checks++;
        if ({done, illegal, WE, DR, Bus} !== {3'b110, 3'd0, 16'h0}) begin
          errors++;
          $display("FAIL illegal_wb done/ill/WE/DR/Bus got %b%b%b/%0d/%h want 110/0/0000",
                   done, illegal, WE, DR, Bus);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({we_seen, done_seen, ill_seen} !== {32'd0, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL illegal_counts WE=%0d done=%0d ill=%0d want 0/1/1", we_seen, done_seen, ill_seen);
    end
    checks++;
    if (nzp !== 3'b001) begin
      errors++;
      $display("FAIL illegal_nzp got %b want 001", nzp);
    end
  endtask

  task automatic test_add_imm();
    run_instr("add_imm", 16'h16FF, 16'h0001, 16'h7777, 3'd3, 3'd7,
              {3'b110, 3'd3, 16'h0000}, 3'b010);
  endtask

  task automatic test_and();
    run_instr("and", 16'h5283, 16'hF0F0, 16'hFF00, 3'd2, 3'd3,
              {3'b110, 3'd1, 16'hF000}, 3'b100);
  endtask

  task automatic test_not();
    run_instr("not", 16'h997F, 16'h0000, 16'h1111, 3'd5, 3'd7,
              {3'b110, 3'd4, 16'hFFFF}, 3'b100);
  endtask

  // start held high: WB lands on cycles 3, 7, 11, 15 after the first accept.
  task automatic test_back_to_back();
    int done_cnt = 0;
    int bad_pos = 0;
    ir = 16'h997F; Out0 = 16'h0000; Out1 = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 16; c++) begin
      if (done) begin
        done_cnt++;
        if ((c % 4) != 3 || Bus !== 16'hFFFF || WE !== 1'b1) bad_pos++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (done_cnt !== 4 || bad_pos !== 0) begin
      errors++;
      $display("FAIL back_to_back done_count=%0d misplaced=%0d want 4/0", done_cnt, bad_pos);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    int we_seen = 0;
    ir = 16'h1001; Out0 = 16'h0005; Out1 = 16'h0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, WE, done, SR0, SR1, nzp} !== {3'b000, 6'd0, 3'b010}) begin
      errors++;
      $display("FAIL abort_state busy/WE/done=%b%b%b SR0=%0d SR1=%0d nzp=%b want 000/0/0/010",
               busy, WE, done, SR0, SR1, nzp);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (WE) we_seen++;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (WE) we_seen++;
      @(negedge clk);
    end
    checks++;
    if (we_seen !== 0) begin
      errors++;
      $display("FAIL abort_no_we WE pulses=%0d want 0", we_seen);
    end
    run_instr("after_abort", 16'h5283, 16'hF0F0, 16'hFF00, 3'd2, 3'd3,
              {3'b110, 3'd1, 16'hF000}, 3'b100);
  endtask

  initial begin
    test_reset();
    test_add();
    test_illegal();
    test_add_imm();
    test_and();
    test_not();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
